// File: rtl/reg_pipeline_elastico.sv
// Elastic register pipeline: PROF chained 2-entry skid stages carrying a TAM-bit
// word with valid/ready on both ends. Every stage's upstream ready is a register
// bit, so backpressure never ripples combinationally through the chain. Global
// parada freezes everything, limpar flushes all entries, and ocupacao reports
// how many words the chain currently holds.
module reg_pipeline_elastico #(
  parameter int TAM   = 32,
  parameter int PROF  = 2,
  parameter int ZERAR = 1,
  localparam int OCW  = $clog2(2 * PROF + 1)
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           parada,
  input  logic           limpar,
  input  logic           entrada_valida,
  input  logic [TAM-1:0] entrada,
  output logic           entrada_pronta,
  output logic           saida_valida,
  output logic [TAM-1:0] saida,
  input  logic           saida_pronta,
  output logic [OCW-1:0] ocupacao
);

  // Stage state encodes (main_v, skid_v); (0,1) cannot be reached.
  typedef enum logic [1:0] {
    VAZIO = 2'b00,
    UM    = 2'b10,
    CHEIO = 2'b11
  } estado_t;

  estado_t        est_q  [PROF];
  estado_t        est_d  [PROF];
  logic [TAM-1:0] main_q [PROF];
  logic [TAM-1:0] main_d [PROF];
  logic [TAM-1:0] skid_q [PROF];
  logic [TAM-1:0] skid_d [PROF];
  logic [TAM-1:0] in_dat [PROF];

  logic [PROF-1:0] in_v;
  logic [PROF-1:0] pronta_inf;
  logic [PROF-1:0] aceita;
  logic [PROF-1:0] entrega;

  logic [OCW-1:0] ocup_d;
  logic [OCW-1:0] ocup_q;

  // Chain wiring: each stage feeds from the previous main register and sees the
  // next stage's registered ready; parada blocks every transfer.
  always_comb begin
    in_v[0]          = entrada_valida;
    in_dat[0]        = entrada;
    pronta_inf[PROF-1] = saida_pronta;
    for (int k = 1; k < PROF; k++) begin
      in_v[k]         = est_q[k-1][1];
      in_dat[k]       = main_q[k-1];
      pronta_inf[k-1] = !est_q[k][0];
    end
    for (int k = 0; k < PROF; k++) begin
      aceita[k]  = in_v[k] & !est_q[k][0] & !parada;
      entrega[k] = est_q[k][1] & pronta_inf[k] & !parada;
    end
  end

  // Next-state of every skid stage and the occupancy it implies.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    ocup_d = '0;
    for (int k = 0; k < PROF; k++) begin
      est_d[k]  = est_q[k];
      main_d[k] = main_q[k];
      skid_d[k] = skid_q[k];
      case (est_q[k])
        VAZIO: begin
          if (aceita[k]) begin
            est_d[k]  = UM;
            main_d[k] = in_dat[k];
          end
        end
        UM: begin
          if (aceita[k] && entrega[k]) begin
            main_d[k] = in_dat[k];
          end else if (aceita[k]) begin
            est_d[k]  = CHEIO;
            skid_d[k] = in_dat[k];
          end else if (entrega[k]) begin
            est_d[k] = VAZIO;
          end
        end
        CHEIO: begin
          if (entrega[k]) begin
            est_d[k]  = UM;
            main_d[k] = skid_q[k];
          end
        end
        default: est_d[k] = VAZIO;
      endcase
      ocup_d = ocup_d + OCW'(est_d[k][1]) + OCW'(est_d[k][0]);
    end
  end

  // State register: async reset, then flush, then normal (parada-gated) update.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      // NOTE: the data registers are reset as well, so saida reads 0 straight
      // out of reset instead of an unknown value.
      for (int k = 0; k < PROF; k++) begin
        est_q[k]  <= VAZIO;
        main_q[k] <= '0;
        skid_q[k] <= '0;
      end
      ocup_q <= '0;
    end else if (limpar) begin
      for (int k = 0; k < PROF; k++) begin
        est_q[k] <= VAZIO;
        if (ZERAR != 0) begin
          main_q[k] <= '0;
          skid_q[k] <= '0;
        end
      end
      ocup_q <= '0;
    end else begin
      for (int k = 0; k < PROF; k++) begin
        est_q[k]  <= est_d[k];
        main_q[k] <= main_d[k];
        skid_q[k] <= skid_d[k];
      end
      ocup_q <= ocup_d;
    end
  end

  assign saida_valida   = est_q[PROF-1][1] & !parada;
  assign entrada_pronta = !est_q[0][0] & !parada;
  assign saida          = main_q[PROF-1];
  assign ocupacao       = ocup_q;

endmodule

// File: doc/reg_pipeline_elastico.md
Name: reg_pipeline_elastico

Overview:
Parametrised successor to the single pipeline register. It is a chain of PROF elastic stages carrying a TAM-bit word with valid/ready handshaking on both ends. Each stage is a 2-entry skid buffer (main plus skid), so backpressure never combinationally crosses a stage. The block keeps the global parada (stall) and limpar (flush) controls, and adds asynchronous reset and an occupancy count. It sits between processor pipeline stages and on the UART data path wherever a producer and consumer may both stall.

Parameters:
TAM, 32, data width in bits (>=1)
PROF, 2, number of elastic stages (>=1)
ZERAR, 1, 1: limpar and reset also zero the data registers; 0: only valid bits cleared
OCW, $clog2(2*PROF+1), width of ocupacao (localparam, derived)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  reset, asynchronous, active-low
parada  in  1  global stall: freeze all state
limpar  in  1  synchronous flush: invalidate all entries
entrada_valida  in  1  upstream word valid
entrada  in  TAM  upstream data
entrada_pronta  out  1  block can accept a word this cycle
saida_valida  out  1  downstream word valid
saida  out  TAM  downstream data
saida_pronta  in  1  downstream accepts this cycle
ocupacao  out  OCW  number of valid entries held in the chain (0..2*PROF)

Behaviour:
- Reset (reset_n=0, async):
  - All main/skid valid bits = 0.
  - Data registers = 0 (regardless of ZERAR).
  - Outputs: saida_valida=0, saida=0, ocupacao=0, entrada_pronta=1 (if parada=0).
- Per-stage state, derived from (main_v, skid_v):
  - VAZIO=(0,0), UM=(1,0), CHEIO=(1,1). (0,1) is illegal and never reached.
  - pronta_sup(k) = !skid_v(k), registered and never dependent on downstream ready.
- Transfers:
  - Upstream transfer into stage k: valid_in(k) & pronta_sup(k).
  - Downstream take from stage k: main_v(k) & pronta_inf(k).
  - Stage 1 input is entrada/entrada_valida. Stage k>1 input is the main of stage k-1.
  - Stage PROF drives saida/saida_valida; pronta_inf(PROF)=saida_pronta.
- Transitions at each edge, when parada=0 and limpar=0:
  - VAZIO: accept -> UM, main<=in. Else stay.
  - UM: accept & take -> UM, main<=in. Accept & !take -> CHEIO, skid<=in. !accept & take -> VAZIO. Neither -> UM, data held.
  - CHEIO: no accept possible. Take -> UM, main<=skid. Else hold.
- Outputs:
  - saida_valida = main_v(PROF) & !parada.
  - entrada_pronta = !skid_v(1) & !parada.
  - saida = main data of stage PROF.
- Latency and ordering:
  - On an empty chain with no backpressure, a word accepted on edge e is on saida after edge e+PROF-1.
  - Throughput is 1 word/clock sustained.
  - Order is strictly preserved; no word is dropped or duplicated.
- parada=1:
  - Every register holds (no transfers at either end).
  - entrada_pronta=0, saida_valida=0; ocupacao holds.
- limpar=1:
  - At the next edge all valid bits go to 0, and ocupacao becomes 0.
  - Data registers are zeroed if ZERAR=1, else held.
  - Priority: reset_n > limpar > parada > normal transfer.
  - A word presented with entrada_valida in the limpar cycle is dropped, even if entrada_pronta was 1.
  - A simultaneous downstream take in that cycle is still counted as delivered by the consumer.
- ocupacao:
  - Registered sum of all main_v and skid_v bits after each edge.
  - Max is 2*PROF; entrada_pronta=0 when skid_v(1)=1.
- Simultaneous accept and take at full occupancy of stage 1 is impossible: pronta is registered, so no combinational ready path exists.
- Reset asserted mid-transfer: all content is lost immediately (async). After reset_n rises, the first edge behaves as from VAZIO.

Test Plan:
- TAM=32, PROF=2, reset then stream 0x00000001..0x00000008 with saida_pronta=1 -> first word on saida after 2nd edge from acceptance; one word/clock; order 1..8; ocupacao steady at 2.
- Fill with saida_pronta=0, feeding 0xA0..0xA5 -> entrada_pronta drops after 4 accepted words; ocupacao=4. Raise saida_pronta -> 0xA0..0xA3 delivered in order, then 0xA4, 0xA5, with no loss.
- Random entrada_valida/saida_pronta patterns (50% each), 1000 words -> scoreboard match; saida_valida never drops while holding a word; entrada_pronta independent of same-cycle saida_pronta.
- Chain holding 3 words, assert parada for 5 cycles with entrada_valida=1 -> entrada_pronta=0, saida_valida=0, ocupacao=3, no state change. Release -> stream resumes with the original words.
- Chain holding 4 words, limpar=1 for one cycle with entrada_valida=1, entrada=0xDEADBEEF -> ocupacao=0 next edge; saida=0 (ZERAR=1); 0xDEADBEEF never appears.
- Drop reset_n mid-stream between edges -> saida_valida=0, saida=0, ocupacao=0 immediately. After release, a new word 0x55 emerges with normal latency.
